// File: rtl/gpu_bus_pkg.sv
// Shared register offsets, fill targets and FSM encoding for the GPU bus sequencer.
package gpu_bus_pkg;

  localparam logic [3:0] REG_TILE_PTR_LO = 4'h0;
  localparam logic [3:0] REG_TILE_PTR_HI = 4'h1;
  localparam logic [3:0] REG_TILE_DATA   = 4'h2;
  localparam logic [3:0] REG_ATTR_PTR_LO = 4'h3;
  localparam logic [3:0] REG_ATTR_PTR_HI = 4'h4;
  localparam logic [3:0] REG_ATTR_DATA   = 4'h5;
  localparam logic [3:0] REG_COLOR_PTR   = 4'h6;
  localparam logic [3:0] REG_COLOR_DATA  = 4'h7;
  localparam logic [3:0] REG_STEP        = 4'h8;
  localparam logic [3:0] REG_FILL_VALUE  = 4'h9;
  localparam logic [3:0] REG_FILL_LEN_LO = 4'hA;
  localparam logic [3:0] REG_FILL_LEN_HI = 4'hB;
  localparam logic [3:0] REG_FILL_GO     = 4'hC;

  localparam logic [1:0] TGT_TILE  = 2'd0;
  localparam logic [1:0] TGT_ATTR  = 2'd1;
  localparam logic [1:0] TGT_COLOR = 2'd2;

  localparam int unsigned FILL_LEN_WIDTH = 12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

endpackage

// File: rtl/cs_strobe_sync.sv
// Brings the asynchronous cs_clock strobe into the core clock domain, keeps the
// bus aligned with it, and produces a one-cycle commit pulse on its falling edge.
module cs_strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic [3:0] addr,
  input  logic       rw,
  input  logic       cs_clock,
  output logic [7:0] held_data,
  output logic [3:0] held_addr,
  output logic       commit_c
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] rw_dly;
  logic [7:0]             data_dly [SYNC_STAGES];
  logic [3:0]             addr_dly [SYNC_STAGES];
  logic                   cs_s;
  logic                   cs_d;
  logic                   held_rw;

  assign cs_s = cs_sync[SYNC_STAGES-1];

  // Strobe synchronizer plus a matching-depth delay line for the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync <= '0;
      rw_dly  <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        data_dly[i] <= '0;
        addr_dly[i] <= '0;
      end
    end else begin
      cs_sync[0]  <= cs_clock;
      rw_dly[0]   <= rw;
      data_dly[0] <= data;
      addr_dly[0] <= addr;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        cs_sync[i]  <= cs_sync[i-1];
        rw_dly[i]   <= rw_dly[i-1];
        data_dly[i] <= data_dly[i-1];
        addr_dly[i] <= addr_dly[i-1];
      end
    end
  end

  // Hold the bus while the strobe is high so it is stable at the falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_d      <= 1'b0;
      held_data <= '0;
      held_addr <= '0;
      held_rw   <= 1'b0;
    end else begin
      cs_d <= cs_s;
      if (cs_s) begin
        held_data <= data_dly[SYNC_STAGES-1];
        held_addr <= addr_dly[SYNC_STAGES-1];
        held_rw   <= rw_dly[SYNC_STAGES-1];
      end
    end
  end

  assign commit_c = cs_d & ~cs_s & ~held_rw;

endmodule

// File: rtl/gpu_bus_sequencer.sv
// CPU register front end: pointer/data-port decode with auto-increment and a
// one-byte-per-clock block-fill engine feeding the tile/attribute/color memories.
module gpu_bus_sequencer
  import gpu_bus_pkg::*;
#(
  parameter int unsigned TILE_ADDR_WIDTH  = 11,
  parameter int unsigned ATTR_ADDR_WIDTH  = 12,
  parameter int unsigned COLOR_ADDR_WIDTH = 4,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic                        CLK100MHz,
  input  logic                        rst,
  input  logic [7:0]                  data,
  input  logic [3:0]                  addr,
  input  logic                        rw,
  input  logic                        cs_clock,
  output logic                        tile_memory_write_enable,
  output logic [TILE_ADDR_WIDTH-1:0]  tile_memory_write_addr,
  output logic [7:0]                  tile_memory_write_data,
  output logic                        attribute_memory_write_enable,
  output logic [ATTR_ADDR_WIDTH-1:0]  attribute_memory_write_addr,
  output logic [7:0]                  attribute_memory_write_data,
  output logic                        color_memory_write_enable,
  output logic [COLOR_ADDR_WIDTH-1:0] color_memory_write_addr,
  output logic [7:0]                  color_memory_write_data,
  output logic                        busy
);

  logic [7:0]                  held_data;
  logic [3:0]                  held_addr;
  logic                        commit_c;

  state_t                      state;
  logic [TILE_ADDR_WIDTH-1:0]  tile_ptr;
  logic [ATTR_ADDR_WIDTH-1:0]  attr_ptr;
  logic [COLOR_ADDR_WIDTH-1:0] color_ptr;
  logic [7:0]                  step;
  logic [7:0]                  fill_value;
  logic [FILL_LEN_WIDTH-1:0]   fill_len;
  logic [FILL_LEN_WIDTH-1:0]   cnt;
  logic [1:0]                  fill_tgt;

  cs_strobe_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (CLK100MHz),
    .rst       (rst),
    .data      (data),
    .addr      (addr),
    .rw        (rw),
    .cs_clock  (cs_clock),
    .held_data (held_data),
    .held_addr (held_addr),
    .commit_c  (commit_c)
  );

  // Register decode, pointer stepping and fill engine; enables are one-cycle pulses
  always_ff @(posedge CLK100MHz or posedge rst) begin
    if (rst) begin
      state                         <= ST_IDLE;
      busy                          <= 1'b0;
      tile_ptr                      <= '0;
      attr_ptr                      <= '0;
      color_ptr                     <= '0;
      step                          <= 8'd1;
      fill_value                    <= '0;
      fill_len                      <= '0;
      cnt                           <= '0;
      fill_tgt                      <= '0;
      tile_memory_write_enable      <= 1'b0;
      tile_memory_write_addr        <= '0;
      tile_memory_write_data        <= '0;
      attribute_memory_write_enable <= 1'b0;
      attribute_memory_write_addr   <= '0;
      attribute_memory_write_data   <= '0;
      color_memory_write_enable     <= 1'b0;
      color_memory_write_addr       <= '0;
      color_memory_write_data       <= '0;
    end else begin
      tile_memory_write_enable      <= 1'b0;
      attribute_memory_write_enable <= 1'b0;
      color_memory_write_enable     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (commit_c) begin
            case (held_addr)
              REG_TILE_PTR_LO: tile_ptr[7:0] <= held_data;
              REG_TILE_PTR_HI: tile_ptr[TILE_ADDR_WIDTH-1:8] <= held_data[TILE_ADDR_WIDTH-9:0];
              REG_TILE_DATA: begin
                tile_memory_write_enable <= 1'b1;
                tile_memory_write_addr   <= tile_ptr;
                tile_memory_write_data   <= held_data;
                tile_ptr                 <= tile_ptr + TILE_ADDR_WIDTH'(step);
              end
              REG_ATTR_PTR_LO: attr_ptr[7:0] <= held_data;
              REG_ATTR_PTR_HI: attr_ptr[ATTR_ADDR_WIDTH-1:8] <= held_data[ATTR_ADDR_WIDTH-9:0];
              REG_ATTR_DATA: begin
                attribute_memory_write_enable <= 1'b1;
                attribute_memory_write_addr   <= attr_ptr;
                attribute_memory_write_data   <= held_data;
                attr_ptr                      <= attr_ptr + ATTR_ADDR_WIDTH'(step);
              end
              REG_COLOR_PTR: color_ptr <= held_data[COLOR_ADDR_WIDTH-1:0];
              REG_COLOR_DATA: begin
                color_memory_write_enable <= 1'b1;
                color_memory_write_addr   <= color_ptr;
                color_memory_write_data   <= held_data;
                color_ptr                 <= color_ptr + COLOR_ADDR_WIDTH'(step);
              end
              REG_STEP:        step           <= held_data;
              REG_FILL_VALUE:  fill_value     <= held_data;
              REG_FILL_LEN_LO: fill_len[7:0]  <= held_data;
              REG_FILL_LEN_HI: fill_len[11:8] <= held_data[3:0];
              REG_FILL_GO: begin
                if (held_data[1:0] != 2'd3 && fill_len != '0) begin
                  state    <= ST_FILL;
                  busy     <= 1'b1;
                  cnt      <= fill_len;
                  fill_tgt <= held_data[1:0];
                end
              end
              default: ;
            endcase
          end
        end
        ST_FILL: begin
          // CPU commits are dropped here; one fill byte per clock
          case (fill_tgt)
            TGT_TILE: begin
              tile_memory_write_enable <= 1'b1;
              tile_memory_write_addr   <= tile_ptr;
              tile_memory_write_data   <= fill_value;
              tile_ptr                 <= tile_ptr + TILE_ADDR_WIDTH'(step);
            end
            TGT_ATTR: begin
              attribute_memory_write_enable <= 1'b1;
              attribute_memory_write_addr   <= attr_ptr;
              attribute_memory_write_data   <= fill_value;
              attr_ptr                      <= attr_ptr + ATTR_ADDR_WIDTH'(step);
            end
            TGT_COLOR: begin
              color_memory_write_enable <= 1'b1;
              color_memory_write_addr   <= color_ptr;
              color_memory_write_data   <= fill_value;
              color_ptr                 <= color_ptr + COLOR_ADDR_WIDTH'(step);
            end
            default: ;
          endcase
          cnt <= cnt - FILL_LEN_WIDTH'(1);
          if (cnt == FILL_LEN_WIDTH'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_bus_sequencer.sv
// Randomized and directed bench for gpu_bus_sequencer against a register-level model.
module tb_gpu_bus_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  data;
  logic [3:0]  addr;
  logic        rw;
  logic        cs_clock;
  logic        tile_we, attr_we, color_we, busy;
  logic [10:0] tile_wa;
  logic [11:0] attr_wa;
  logic [3:0]  color_wa;
  logic [7:0]  tile_wd, attr_wd, color_wd;

  gpu_bus_sequencer dut (
    .CLK100MHz                     (clk),
    .rst                           (rst),
    .data                          (data),
    .addr                          (addr),
    .rw                            (rw),
    .cs_clock                      (cs_clock),
    .tile_memory_write_enable      (tile_we),
    .tile_memory_write_addr        (tile_wa),
    .tile_memory_write_data        (tile_wd),
    .attribute_memory_write_enable (attr_we),
    .attribute_memory_write_addr   (attr_wa),
    .attribute_memory_write_data   (attr_wd),
    .color_memory_write_enable     (color_we),
    .color_memory_write_addr       (color_wa),
    .color_memory_write_data       (color_wd),
    .busy                          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int obs_q[$];
  int exp_q[$];
  int busy_cycles = 0;
  int multi_en    = 0;

  // Model state: memory pointers and config registers as the CPU sees them
  int m_tile, m_attr, m_color, m_step, m_fval, m_flen;

  task automatic check(input string tag, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  function automatic int pack(input int mem, input int a, input int d);
    return (mem << 20) | (a << 8) | (d & 'hFF);
  endfunction

  function automatic bit any_en();
    return tile_we | attr_we | color_we;
  endfunction

  function automatic void model_reset();
    m_tile = 0; m_attr = 0; m_color = 0; m_step = 1; m_fval = 0; m_flen = 0;
  endfunction

  function automatic void model_port_write(input int mem, input int d);
    case (mem)
      0: begin exp_q.push_back(pack(0, m_tile, d));  m_tile  = (m_tile  + m_step) % 2048; end
      1: begin exp_q.push_back(pack(1, m_attr, d));  m_attr  = (m_attr  + m_step) % 4096; end
      default: begin exp_q.push_back(pack(2, m_color, d)); m_color = (m_color + m_step) % 16; end
    endcase
  endfunction

  function automatic void model_commit(input int a, input int d);
    case (a)
      0:  m_tile  = (m_tile & 'h700) | d;
      1:  m_tile  = (m_tile & 'h0FF) | ((d & 7) << 8);
      2:  model_port_write(0, d);
      3:  m_attr  = (m_attr & 'hF00) | d;
      4:  m_attr  = (m_attr & 'h0FF) | ((d & 15) << 8);
      5:  model_port_write(1, d);
      6:  m_color = d & 15;
      7:  model_port_write(2, d);
      8:  m_step  = d;
      9:  m_fval  = d;
      10: m_flen  = (m_flen & 'hF00) | d;
      11: m_flen  = (m_flen & 'h0FF) | ((d & 15) << 8);
      12: if ((d & 3) != 3 && m_flen != 0)
            for (int i = 0; i < m_flen; i++) model_port_write(d & 3, m_fval);
      default: ;
    endcase
  endfunction

  // Collect every write the DUT issues, in order, and track busy / enable exclusivity
  always @(negedge clk) begin
    if (!rst) begin
      if (int'(tile_we) + int'(attr_we) + int'(color_we) > 1) multi_en++;
      if (tile_we)  obs_q.push_back(pack(0, int'(tile_wa),  int'(tile_wd)));
      if (attr_we)  obs_q.push_back(pack(1, int'(attr_wa),  int'(attr_wd)));
      if (color_we) obs_q.push_back(pack(2, int'(color_wa), int'(color_wd)));
      if (busy) busy_cycles++;
    end
  end

  // One CPU bus cycle; drop=1 means the model expects the DUT to ignore it
  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d, input logic r, input bit drop);
    bit is_port;
    bit extra;
    int lat;
    is_port = (a == 4'h2 || a == 4'h5 || a == 4'h7) && !r && !drop;
    @(negedge clk);
    addr = a; data = d; rw = r; cs_clock = 1'b1;
    repeat (4) @(negedge clk);
    cs_clock = 1'b0;
    lat = 0;
    extra = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (any_en()) begin
        if (lat == 0) lat = i;
        else if (i == lat + 1) extra = 1'b1;
      end
    end
    if (is_port) begin
      check("wr_latency", lat, (lat == 3) ? 3 : 4);
      check("wr_one_cycle", int'(extra), 0);
    end
    if (!drop && !r) model_commit(int'(a), int'(d));
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == 5000) check("idle_timeout", 0, 1);
  endtask

  task automatic compare_queues(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_write"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int i;
    rst = 1'b1; data = '0; addr = '0; rw = 1'b0; cs_clock = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_tile_we", int'(tile_we), 0);
    check("rst_attr_we", int'(attr_we), 0);
    check("rst_color_we", int'(color_we), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tile_addr", int'(tile_wa), 0);
    check("rst_attr_addr", int'(attr_wa), 0);
    check("rst_color_addr", int'(color_wa), 0);
    check("rst_data", int'(tile_wd | attr_wd | color_wd), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Tile pointer + data port auto-increment
    cpu_write(4'h0, 8'h34, 1'b0, 1'b0);
    cpu_write(4'h1, 8'h05, 1'b0, 1'b0);
    cpu_write(4'h2, 8'hAA, 1'b0, 1'b0);
    cpu_write(4'h2, 8'hBB, 1'b0, 1'b0);
    check("tile_first_addr", (exp_q.size() > 0) ? exp_q[0] : -1, pack(0, 'h534, 'hAA));
    compare_queues("tile");

    // Color pointer wrap with STEP=4
    cpu_write(4'h8, 8'h04, 1'b0, 1'b0);
    cpu_write(4'h6, 8'h0E, 1'b0, 1'b0);
    cpu_write(4'h7, 8'h11, 1'b0, 1'b0);
    cpu_write(4'h7, 8'h22, 1'b0, 1'b0);
    cpu_write(4'h7, 8'h33, 1'b0, 1'b0);
    compare_queues("color_wrap");

    // Attribute fill across the pointer wrap
    cpu_write(4'h8, 8'h01, 1'b0, 1'b0);
    cpu_write(4'h3, 8'hFE, 1'b0, 1'b0);
    cpu_write(4'h4, 8'h0F, 1'b0, 1'b0);
    cpu_write(4'h9, 8'h5A, 1'b0, 1'b0);
    cpu_write(4'hA, 8'h03, 1'b0, 1'b0);
    cpu_write(4'hB, 8'h00, 1'b0, 1'b0);
    busy_cycles = 0;
    cpu_write(4'hC, 8'h01, 1'b0, 1'b0);
    wait_idle();
    check("attr_fill_busy", busy_cycles, 3);
    cpu_write(4'h5, 8'hC3, 1'b0, 1'b0);
    compare_queues("attr_fill");

    // Degenerate fills: zero length, then invalid target
    busy_cycles = 0;
    cpu_write(4'hA, 8'h00, 1'b0, 1'b0);
    cpu_write(4'hC, 8'h00, 1'b0, 1'b0);
    cpu_write(4'hA, 8'h03, 1'b0, 1'b0);
    cpu_write(4'hC, 8'h03, 1'b0, 1'b0);
    wait_idle();
    check("nop_fill_busy", busy_cycles, 0);
    compare_queues("nop_fill");

    // CPU writes during a long fill are dropped
    cpu_write(4'h0, 8'h10, 1'b0, 1'b0);
    cpu_write(4'h1, 8'h00, 1'b0, 1'b0);
    cpu_write(4'h9, 8'hE7, 1'b0, 1'b0);
    cpu_write(4'hA, 8'd100, 1'b0, 1'b0);
    busy_cycles = 0;
    cpu_write(4'hC, 8'h00, 1'b0, 1'b0);
    cpu_write(4'h2, 8'h11, 1'b0, 1'b1);
    cpu_write(4'h0, 8'h00, 1'b0, 1'b1);
    wait_idle();
    check("tile_fill_busy", busy_cycles, 100);
    cpu_write(4'h2, 8'h42, 1'b0, 1'b0);
    check("tile_ptr_after_fill", (m_tile + 2047) % 2048, 'h10 + 100);
    compare_queues("tile_fill");

    // Randomized register traffic, including read strobes
    for (int k = 0; k < 60; k++) begin
      logic [3:0] a;
      logic [7:0] d;
      logic       r;
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom);
      if (a == 4'hB) d = 8'h00;
      if (a == 4'hA) d = d & 8'h1F;
      r = ($urandom_range(0, 7) == 0);
      cpu_write(a, d, r, 1'b0);
      wait_idle();
    end
    compare_queues("random");

    // Reset in the middle of a fill
    cpu_write(4'hA, 8'd50, 1'b0, 1'b0);
    cpu_write(4'hB, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    addr = 4'hC; data = 8'h00; rw = 1'b0; cs_clock = 1'b1;
    repeat (4) @(negedge clk);
    cs_clock = 1'b0;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) break;
    end
    check("fill_started", int'(busy), 1);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_enables", int'(tile_we) + int'(attr_we) + int'(color_we), 0);
    check("midrst_busy", int'(busy), 0);
    model_reset();
    obs_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no_write_after_rst", obs_q.size(), 0);
    cpu_write(4'h2, 8'h77, 1'b0, 1'b0);
    cpu_write(4'h5, 8'h66, 1'b0, 1'b0);
    cpu_write(4'h7, 8'h55, 1'b0, 1'b0);
    cpu_write(4'h2, 8'h99, 1'b1, 1'b0);
    check("post_rst_tile_addr", (exp_q.size() > 0) ? exp_q[0] : -1, pack(0, 0, 'h77));
    compare_queues("post_rst");

    check("single_enable", multi_en, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
